// File: rtl/cmp_pkg.sv
// Shared types and helpers for the shared compare unit: op encoding and result mapping.
package cmp_pkg;

  localparam int CMP_OP_W = 3;

  typedef enum logic [CMP_OP_W-1:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LT  = 3'd2,
    CMP_GE  = 3'd3,
    CMP_LTU = 3'd4,
    CMP_GEU = 3'd5
  } cmp_op_e;

  // Codes 6 and 7 have no meaning.
  function automatic logic cmp_is_legal(logic [CMP_OP_W-1:0] code);
    return code <= CMP_OP_W'(CMP_GEU);
  endfunction

  // Signed ops are turned into unsigned ones by flipping the sign bits.
  function automatic logic cmp_is_signed(cmp_op_e op);
    return (op == CMP_LT) || (op == CMP_GE);
  endfunction

  // Map the raw comparator flags onto the boolean the requester asked for.
  function automatic logic cmp_resolve(cmp_op_e op, logic eq, logic lt);
    logic res;
    case (op)
      CMP_EQ:           res = eq;
      CMP_NE:           res = ~eq;
      CMP_LT, CMP_LTU:  res = lt;
      CMP_GE, CMP_GEU:  res = ~lt;
      default:          res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cmp_mag32.sv
// The 32-bit unsigned magnitude comparator shared between requesters.
module cmp_mag32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        eq,
  output logic        lt
);

  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               take,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id
);

  localparam int PAD = 1 << IDW;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nxt;
  logic [PAD-1:0] req_pad;
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;
  logic           found;

  // Requests padded to the full index range so any IDW-bit index is in bounds.
  assign req_pad = PAD'(req);

  // Scan from the pointer, wrapping modulo NUM_REQ, and pick the first valid requester.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    found  = 1'b0;
    gnt_id = '0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
      idx = sum[IDW-1:0];
      if (!found && req_pad[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
  end

  // One-hot grant decoded from the winner index.
  always_comb begin
    gnt = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      gnt[r] = found && (gnt_id == IDW'(r));
    end
  end

  // Pointer moves to the slot after the winner, wrapping modulo NUM_REQ.
  always_comb begin
    ptr_nxt = gnt_id + IDW'(1);
    if ({1'b0, gnt_id} == (IDW+1)'(NUM_REQ - 1)) ptr_nxt = '0;
  end

  // Pointer register: only a taken grant moves it.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      ptr <= '0;
    end else if (take) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Shares one 32-bit comparator between NUM_REQ requesters: round-robin grant,
// operand register, then comparator plus result register (fixed latency 2).
module cmp_share_arbiter
  import cmp_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  output logic [NUM_REQ-1:0]    o_req_ready,
  input  logic [NUM_REQ*3-1:0]  i_req_op,
  input  logic [NUM_REQ*32-1:0] i_req_a,
  input  logic [NUM_REQ*32-1:0] i_req_b,
  output logic                  o_rsp_valid,
  output logic [IDW-1:0]        o_rsp_id,
  output logic                  o_rsp_result,
  output logic                  o_rsp_eq,
  output logic                  o_rsp_lt,
  output logic                  o_busy
);

  logic [NUM_REQ-1:0]  arb_req;
  logic [NUM_REQ-1:0]  gnt;
  logic [IDW-1:0]      gnt_id;
  logic                take;

  logic [CMP_OP_W-1:0] sel_op;
  logic [31:0]         sel_a;
  logic [31:0]         sel_b;
  logic                cap_legal;
  cmp_op_e             cap_op;
  logic                cap_flip;

  logic                s1_valid;
  logic [31:0]         s1_a;
  logic [31:0]         s1_b;
  cmp_op_e             s1_op;
  logic [IDW-1:0]      s1_id;
  logic                s1_kill;

  logic                cmp_eq;
  logic                cmp_lt;

  // A flush hides every request, so nothing is granted and the pointer holds.
  assign arb_req     = i_req_valid & {NUM_REQ{~i_flush}};
  assign take        = |gnt;
  assign o_req_ready = gnt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .req    (arb_req),
    .take   (take),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (gnt[r]) begin
        sel_op = i_req_op[r*CMP_OP_W +: CMP_OP_W];
        sel_a  = i_req_a[r*32 +: 32];
        sel_b  = i_req_b[r*32 +: 32];
      end
    end
  end

  // Illegal codes run as EQ with the result killed; signed ops flip both sign bits.
  assign cap_legal = cmp_is_legal(sel_op);
  assign cap_op    = cap_legal ? cmp_op_e'(sel_op) : CMP_EQ;
  assign cap_flip  = cmp_is_signed(cap_op);

  // Stage-1 valid bit: set by a taken grant, cleared by flush.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= take & ~i_flush;
    end
  end

  // Stage-1 operand capture.
  always_ff @(posedge i_clk) begin
    // NOTE: payload registers carry no reset; only the valid bits gate their use.
    if (take) begin
      s1_a    <= {sel_a[31] ^ cap_flip, sel_a[30:0]};
      s1_b    <= {sel_b[31] ^ cap_flip, sel_b[30:0]};
      s1_op   <= cap_op;
      s1_id   <= gnt_id;
      s1_kill <= ~cap_legal;
    end
  end

  cmp_mag32 u_cmp (
    .a  (s1_a),
    .b  (s1_b),
    .eq (cmp_eq),
    .lt (cmp_lt)
  );

  // Stage-2 result register; the valid bit is the one-cycle response pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_valid  <= 1'b0;
      o_rsp_id     <= '0;
      o_rsp_result <= 1'b0;
      o_rsp_eq     <= 1'b0;
      o_rsp_lt     <= 1'b0;
    end else begin
      o_rsp_valid <= s1_valid & ~i_flush;
      if (s1_valid) begin
        o_rsp_id     <= s1_id;
        o_rsp_result <= ~s1_kill & cmp_resolve(s1_op, cmp_eq, cmp_lt);
        o_rsp_eq     <= cmp_eq;
        o_rsp_lt     <= cmp_lt;
      end
    end
  end

  assign o_busy = s1_valid | o_rsp_valid;

endmodule
